// File: rtl/jpeg_quant_pkg.sv
// Shared types for the JPEG quantizer scheduling slice: coefficients, 8x8 blocks,
// colour components and scheduler FSM states.
package jpeg_quant_pkg;

  typedef logic signed [10:0] coef_t;
  typedef coef_t [0:7][0:7] block_t;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } qsched_state_t;

  function automatic logic [2:0] comp_onehot(comp_t c);
    return 3'b001 << c;
  endfunction

endpackage

// File: rtl/qsched_mcu_seq.sv
// MCU order sequencer: walks Y slots 0..Y_PER_MCU-1, then Cb, then Cr, and counts
// completed MCUs. Advances only on the block-accept strobe.
module qsched_mcu_seq
  import jpeg_quant_pkg::*;
#(
  parameter int unsigned Y_PER_MCU = 1,
  parameter int unsigned MCU_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance,
  output comp_t                comp,
  output logic [MCU_CNT_W-1:0] mcu,
  output logic                 mcu_done
);

  logic [1:0]           y_slot_q;
  comp_t                comp_q;
  logic [MCU_CNT_W-1:0] mcu_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_slot_q <= '0;
      comp_q   <= COMP_Y;
      mcu_q    <= '0;
    end else if (advance) begin
      case (comp_q)
        COMP_Y: begin
          if (y_slot_q == 2'(Y_PER_MCU - 1)) begin
            y_slot_q <= '0;
            comp_q   <= COMP_CB;
          end else begin
            y_slot_q <= y_slot_q + 2'd1;
          end
        end
        COMP_CB: comp_q <= COMP_CR;
        default: begin
          // Cr closes the MCU; the index wraps naturally at 2^MCU_CNT_W.
          comp_q <= COMP_Y;
          mcu_q  <= mcu_q + 1'b1;
        end
      endcase
    end
  end

  assign comp     = comp_q;
  assign mcu      = mcu_q;
  assign mcu_done = advance && (comp_q == COMP_CR);

endmodule

// File: rtl/quant_mcu_scheduler.sv
// Feeds Y/Cb/Cr DCT blocks through one shared quantizer core in MCU order and
// hands results downstream. Optional quantizer watchdog: define QSCHED_TIMEOUT_EN.
module quant_mcu_scheduler
  import jpeg_quant_pkg::*;
#(
  parameter int unsigned Y_PER_MCU      = 1,
  parameter int unsigned MCU_CNT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           in_valid,
  output logic [2:0]           in_ready,
  input  block_t [2:0]         in_blk,
  output logic                 q_enable,
  output comp_t                q_sel,
  output block_t               q_Z,
  input  logic                 q_out_enable,
  input  block_t               q_Q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output comp_t                out_comp,
  output block_t               out_Q,
  output logic [MCU_CNT_W-1:0] out_mcu,
  output logic                 mcu_done,
  output logic                 q_timeout
);

  qsched_state_t        state_q, state_d;
  block_t               blk_q, res_q;
  comp_t                comp;
  logic [MCU_CNT_W-1:0] mcu;
  logic [2:0]           sched_oh;
  logic                 take, capture, timeout_hit, advance, wd_expired;

  qsched_mcu_seq #(
    .Y_PER_MCU (Y_PER_MCU),
    .MCU_CNT_W (MCU_CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .comp     (comp),
    .mcu      (mcu),
    .mcu_done (mcu_done)
  );

  assign sched_oh = comp_onehot(comp);
  assign take     = (state_q == IDLE) && |(in_valid & sched_oh);
  // Held at zero while reset is asserted so every output reads 0 in reset.
  assign in_ready = (state_q == IDLE && !rst) ? sched_oh : 3'b000;

  always_comb begin
    state_d     = state_q;
    q_enable    = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE:  if (take) state_d = ISSUE;
      ISSUE: begin
        q_enable = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (q_out_enable) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          advance = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) blk_q <= in_blk[comp];
      if (capture) res_q <= q_Q;
      else if (timeout_hit) res_q <= '0;
    end
  end

`ifdef QSCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q;
  logic           timeout_q;

  // Counter is zero on the first WAIT cycle, so expiry lands TIMEOUT_CYCLES after entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == WAIT) ? wd_cnt_q + 1'b1 : '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign wd_expired = (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1));
  assign q_timeout  = timeout_q;
`else
  assign wd_expired = 1'b0;
  assign q_timeout  = 1'b0;
`endif

  assign q_sel     = comp;
  assign q_Z       = blk_q;
  assign out_valid = (state_q == HOLD);
  assign out_comp  = comp;
  assign out_Q     = res_q;
  assign out_mcu   = mcu;

endmodule

// File: tb/tb_quant_mcu_scheduler.sv
// Bench for quant_mcu_scheduler: a 4:4:4 instance and a 4:2:0 instance, each
// driven by a stub core whose result is the input block shifted right by two.
`timescale 1ns/1ps
module tb_quant_mcu_scheduler;
  import jpeg_quant_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  in_valid [2];
  logic [2:0]  in_ready [2];
  block_t [2:0] in_blk;
  logic        q_enable [2];
  comp_t       q_sel [2];
  block_t      q_Z [2];
  logic        q_out_enable [2];
  block_t      q_Q [2];
  logic        out_valid [2];
  logic        out_ready [2];
  comp_t       out_comp [2];
  block_t      out_Q [2];
  logic [15:0] out_mcu [2];
  logic        mcu_done [2];
  logic        q_timeout [2];

  quant_mcu_scheduler #(.Y_PER_MCU(1), .MCU_CNT_W(16), .TIMEOUT_CYCLES(TO)) u_dut_444 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_blk(in_blk),
    .q_enable(q_enable[0]), .q_sel(q_sel[0]), .q_Z(q_Z[0]), .q_out_enable(q_out_enable[0]),
    .q_Q(q_Q[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_comp(out_comp[0]),
    .out_Q(out_Q[0]), .out_mcu(out_mcu[0]), .mcu_done(mcu_done[0]), .q_timeout(q_timeout[0])
  );

  quant_mcu_scheduler #(.Y_PER_MCU(4), .MCU_CNT_W(16), .TIMEOUT_CYCLES(TO)) u_dut_420 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_blk(in_blk),
    .q_enable(q_enable[1]), .q_sel(q_sel[1]), .q_Z(q_Z[1]), .q_out_enable(q_out_enable[1]),
    .q_Q(q_Q[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_comp(out_comp[1]),
    .out_Q(out_Q[1]), .out_mcu(out_mcu[1]), .mcu_done(mcu_done[1]), .q_timeout(q_timeout[1])
  );

  function automatic block_t shr2(block_t b);
    block_t r;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        r[i][j] = coef_t'($signed(b[i][j]) >>> 2);
    return r;
  endfunction

  // 200+ above the anti-diagonal, 50 on it, -1/0/1 below.
  function automatic block_t pat(int c, int s);
    block_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i + j < 7)       b[i][j] = coef_t'(200 + i + 8 * s + 64 * c);
        else if (i + j == 7) b[i][j] = coef_t'(50);
        else                 b[i][j] = coef_t'(((i + j + c + s) % 3) - 1);
    return b;
  endfunction

  // Stub core: fixed latency, result = Z >>> 2, optionally silent.
  int     lat = 3;
  bit     mute = 1'b0;
  logic   spur [2] = '{1'b0, 1'b0};
  int     stub_cnt [2];
  block_t zcap [2];

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        stub_cnt[d] <= 0;
        zcap[d]     <= '0;
      end else if (q_enable[d]) begin
        stub_cnt[d] <= lat;
        zcap[d]     <= q_Z[d];
      end else if (stub_cnt[d] != 0) begin
        stub_cnt[d] <= stub_cnt[d] - 1;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      q_out_enable[d] = ((stub_cnt[d] == 1) && !mute) || spur[d];
      q_Q[d]          = shr2(zcap[d]);
    end
  end

  int    cyc = 0;
  int    qen_cnt [2] = '{0, 0};
  int    qen_cyc [2] = '{0, 0};
  comp_t last_sel [2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++)
      if (q_enable[d]) begin
        qen_cnt[d]  <= qen_cnt[d] + 1;
        qen_cyc[d]  <= cyc;
        last_sel[d] <= q_sel[d];
      end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input block_t act, input block_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    int         d;
    logic [2:0] valid;
    int         seed;
    comp_t      comp;
    int         mcu;
    bit         done;
    int         hold;
    bit         spot;
  } vec_t;

  task automatic set_blocks(input int s);
    for (int c = 0; c < 3; c++) in_blk[c] = pat(c, s);
  endtask

  task automatic run_vec(input vec_t v);
    int     n;
    int     q0;
    block_t exp;
    q0  = qen_cnt[v.d];
    exp = shr2(pat(int'(v.comp), v.seed));
    set_blocks(v.seed);
    in_valid[v.d]  = v.valid;
    out_ready[v.d] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid[v.d] && n < 60) begin
      @(negedge clk);
      n++;
    end
    in_valid[v.d] = 3'b000;
    chk("out_valid", 64'(out_valid[v.d]), 64'd1);
    chk("out_comp", 64'(out_comp[v.d]), 64'(v.comp));
    chk("out_mcu", 64'(out_mcu[v.d]), 64'(v.mcu));
    chk_blk("out_Q", out_Q[v.d], exp);
    chk("q_sel", 64'(last_sel[v.d]), 64'(v.comp));
    chk("in_ready_hold", 64'(in_ready[v.d]), 64'd0);
    if (v.spot) begin
      chk("q00", 64'(out_Q[v.d][0][0]), 64'd50);
      chk("q70", 64'(out_Q[v.d][7][0]), 64'd12);
      chk("q77", 64'(out_Q[v.d][7][7]), 64'd0);
    end
    for (int k = 0; k < v.hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid[v.d]), 64'd1);
      chk_blk("hold_Q", out_Q[v.d], exp);
      chk("hold_in_ready", 64'(in_ready[v.d]), 64'd0);
    end
    chk("qen_once", 64'(qen_cnt[v.d] - q0), 64'd1);
    out_ready[v.d] = 1'b1;
    #1;
    chk("mcu_done", 64'(mcu_done[v.d]), 64'(v.done));
    @(negedge clk);
    out_ready[v.d] = 1'b0;
    chk("accepted", 64'(out_valid[v.d]), 64'd0);
  endtask

  vec_t v420 [$];
  vec_t v444 [$];

  initial begin
    int n;
    int q0;

    v420.push_back('{1, 3'b011, 1, COMP_Y,  0, 1'b0, 0,  1'b0});
    v420.push_back('{1, 3'b001, 2, COMP_Y,  0, 1'b0, 0,  1'b0});
    v420.push_back('{1, 3'b111, 3, COMP_Y,  0, 1'b0, 0,  1'b0});
    v420.push_back('{1, 3'b001, 4, COMP_Y,  0, 1'b0, 0,  1'b0});
    v420.push_back('{1, 3'b010, 5, COMP_CB, 0, 1'b0, 0,  1'b0});
    v420.push_back('{1, 3'b100, 6, COMP_CR, 0, 1'b1, 10, 1'b0});
    v420.push_back('{1, 3'b001, 7, COMP_Y,  1, 1'b0, 0,  1'b0});

    v444.push_back('{0, 3'b111, 0, COMP_Y,  0, 1'b0, 0,  1'b1});
    v444.push_back('{0, 3'b111, 1, COMP_CB, 0, 1'b0, 0,  1'b0});
    v444.push_back('{0, 3'b111, 2, COMP_CR, 0, 1'b1, 0,  1'b0});
    v444.push_back('{0, 3'b111, 3, COMP_Y,  1, 1'b0, 0,  1'b0});

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 3'b000;
      out_ready[d] = 1'b0;
    end
    set_blocks(0);
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", 64'(out_valid[d]), 64'd0);
      chk("rst_in_ready", 64'(in_ready[d]), 64'd0);
      chk("rst_q_enable", 64'(q_enable[d]), 64'd0);
      chk("rst_out_mcu", 64'(out_mcu[d]), 64'd0);
      chk_blk("rst_out_Q", out_Q[d], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready[1]), 64'd1);

    // Stray core strobe while idle must not produce output.
    spur[1] = 1'b1;
    @(negedge clk);
    spur[1] = 1'b0;
    @(negedge clk);
    chk("spur_ignored", 64'(out_valid[1]), 64'd0);

    // Only Cb valid while a Y slot is scheduled: stalls.
    in_valid[1] = 3'b010;
    repeat (10) @(negedge clk);
    chk("cb_stall_ready", 64'(in_ready[1]), 64'd1);
    chk("cb_stall_noqen", 64'(qen_cnt[1]), 64'd0);
    in_valid[1] = 3'b000;

    lat = 1;
    for (int i = 0; i < 4; i++) run_vec(v420[i]);
    chk("after_4y_ready", 64'(in_ready[1]), 64'd2);
    for (int i = 4; i < v420.size(); i++) run_vec(v420[i]);

    lat = 3;
    for (int i = 0; i < v444.size(); i++) run_vec(v444[i]);

    // Reset in the middle of WAIT.
    lat = 20;
    q0 = qen_cnt[0];
    in_valid[0] = 3'b111;
    n = 0;
    while (qen_cnt[0] == q0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midwait_qen", 64'(qen_cnt[0] != q0), 64'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_ready", 64'(in_ready[0]), 64'd0);
    chk("mid_rst_qen", 64'(q_enable[0]), 64'd0);
    chk("mid_rst_mcu", 64'(out_mcu[0]), 64'd0);
    chk("mid_rst_mcu420", 64'(out_mcu[1]), 64'd0);
    chk_blk("mid_rst_Q", out_Q[0], '0);
    in_valid[0] = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    lat = 3;
    run_vec('{0, 3'b111, 5, COMP_Y, 0, 1'b0, 0, 1'b0});

`ifdef QSCHED_TIMEOUT_EN
    mute = 1'b1;
    q0 = qen_cnt[1];
    in_valid[1] = 3'b001;
    set_blocks(6);
    n = 0;
    while (!out_valid[1] && n < 60) begin
      @(negedge clk);
      n++;
    end
    in_valid[1] = 3'b000;
    chk("to_valid", 64'(out_valid[1]), 64'd1);
    chk("to_delay", 64'(cyc - qen_cyc[1] - 1), 64'(TO));
    chk_blk("to_zero_Q", out_Q[1], '0);
    chk("to_flag", 64'(q_timeout[1]), 64'd1);
    chk("to_comp", 64'(out_comp[1]), 64'(COMP_Y));
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_sticky", 64'(q_timeout[1]), 64'd1);
    chk("to_other_clear", 64'(q_timeout[0]), 64'd0);
`else
    chk("no_timeout0", 64'(q_timeout[0]), 64'd0);
    chk("no_timeout1", 64'(q_timeout[1]), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
